ysyx_24100005_ifu_pc: RTL and testbench

//  Parametrised PC generator and instruction-fetch front end for the NPC core.

---
 rtl/ysyx_24100005_ifu_pc.sv | 182 ++++++++++++++++++
 tb/tb_ysyx_24100005_ifu_pc.sv | 465 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24100005_ifu_pc.sv
// ysyx_24100005_ifu_pc: PC generator and instruction-fetch front end.
// Holds the architectural PC and issues one valid/ready fetch at a time to imem.
// It buffers the returned instruction for decode, and applies trap/branch
// redirects, killing a fetch that is already in flight.
// Optional feature macro: YSYX_IFU_ALIGN_CHK_EN (reject misaligned targets).
module ysyx_24100005_ifu_pc #(
    parameter int unsigned          XLEN       = 32,
    parameter int unsigned          ILEN       = 32,
    parameter logic [XLEN-1:0]      RESET_VEC  = 32'h8000_0000,
    parameter int unsigned          INST_BYTES = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_pc,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [XLEN-1:0] req_pc,
    input  logic            resp_valid,
    input  logic [ILEN-1:0] resp_inst,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ILEN-1:0] out_inst,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] snpc,
    output logic            misalign_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t          state, state_d;
    logic [XLEN-1:0] pc, pc_d;
    logic            kill, kill_d;
    logic            out_valid_d;
    logic [ILEN-1:0] out_inst_d;
    logic [XLEN-1:0] out_pc_d;

    // Redirect target selection: a trap always wins over a branch/jump.
    logic            take;
    logic [XLEN-1:0] target_raw;
    logic [XLEN-1:0] target;
    logic            accept;

    assign take       = trap_valid | redirect_valid;
    assign target_raw = trap_valid ? trap_pc : redirect_pc;

`ifdef YSYX_IFU_ALIGN_CHK_EN
    // A misaligned target is refused outright; the core keeps running from
    // the current PC and the error is reported on the following cycle.
    logic target_bad;
    logic misalign_q;

    assign target_bad = take && (target_raw[1:0] != 2'b00);
    assign target     = target_raw;
    assign accept     = take && !target_bad;

    // Register the misalignment flag so it pulses one cycle after the redirect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= target_bad;
        end
    end

    assign misalign_err = misalign_q;
`else
    // Without the check, the low address bits are simply cleared so the PC
    // can never leave word alignment.
    assign target       = target_raw & ~XLEN'(3);
    assign accept       = take;
    assign misalign_err = 1'b0;
`endif

    assign snpc   = pc + XLEN'(INST_BYTES);
    assign req_pc = pc;

    // Next-state, next-PC and fetch handshake logic.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_d     = state;
        pc_d        = pc;
        kill_d      = kill;
        out_valid_d = out_valid;
        out_inst_d  = out_inst;
        out_pc_d    = out_pc;
        req_valid   = 1'b0;

        case (state)
            S_IDLE: begin
                // Any response showing up here belongs to a pre-reset fetch.
                state_d = S_FETCH;
                if (accept) begin
                    pc_d = target;
                end
            end

            S_FETCH: begin
                // Hold the request back during a redirect so no request can
                // carry the stale PC.
                req_valid = !take;
                if (accept) begin
                    pc_d = target;
                end else if (req_valid && req_ready) begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (accept) begin
                    pc_d = target;
                    if (resp_valid) begin
                        // The in-flight response lands right now: drop it.
                        kill_d  = 1'b0;
                        state_d = S_FETCH;
                    end else begin
                        // Remember to discard the response when it arrives.
                        kill_d = 1'b1;
                    end
                end else if (resp_valid) begin
                    if (kill) begin
                        kill_d  = 1'b0;
                        state_d = S_FETCH;
                    end else begin
                        out_valid_d = 1'b1;
                        out_inst_d  = resp_inst;
                        out_pc_d    = pc;
                        state_d     = S_HOLD;
                    end
                end
            end

            S_HOLD: begin
                if (accept) begin
                    // Consumed or not, the buffered instruction is dropped
                    // and the PC jumps straight to the target.
                    pc_d        = target;
                    out_valid_d = 1'b0;
                    state_d     = S_FETCH;
                end else if (out_ready) begin
                    pc_d        = snpc;
                    out_valid_d = 1'b0;
                    state_d     = S_FETCH;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, PC and output-buffer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            pc        <= RESET_VEC;
            kill      <= 1'b0;
            out_valid <= 1'b0;
            out_inst  <= '0;
            out_pc    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of its neighbours.
            state     <= state_d;
            pc        <= pc_d;
            kill      <= kill_d;
            out_valid <= out_valid_d;
            out_inst  <= out_inst_d;
            out_pc    <= out_pc_d;
        end
    end

endmodule

// File: tb/tb_ysyx_24100005_ifu_pc.sv
// Testbench for ysyx_24100005_ifu_pc: an imem responder plus a transaction-level
// reference model. The model tracks the next PC to deliver, whether one
// instruction is buffered, and whether one fetch is outstanding.
module tb_ysyx_24100005_ifu_pc;

    localparam logic [31:0] RESET_VEC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        trap_valid = 1'b0;
    logic [31:0] trap_pc = '0;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [31:0] req_pc;
    logic        resp_valid = 1'b0;
    logic [31:0] resp_inst = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [31:0] snpc;
    logic        misalign_err;

    ysyx_24100005_ifu_pc dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .trap_valid    (trap_valid),
        .trap_pc       (trap_pc),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_pc        (req_pc),
        .resp_valid    (resp_valid),
        .resp_inst     (resp_inst),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_inst      (out_inst),
        .out_pc        (out_pc),
        .snpc          (snpc),
        .misalign_err  (misalign_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    logic [31:0] exp_pc;
    logic        exp_idle;
    logic        exp_valid;
    logic [31:0] exp_inst;
    logic        exp_mis;
    // imem model state.
    logic        mem_busy;
    logic        mem_killed;
    logic [31:0] mem_addr;
    int          mem_cnt;
    int          lat_min = 1;
    int          lat_max = 1;
    logic        const_inst = 1'b1;
    logic        late_resp = 1'b0;
    // Per-cycle observations for scenario tasks.
    logic        last_hs;
    logic [31:0] last_hs_pc;
    logic        last_deliver;
    logic [31:0] last_deliver_pc;
    logic [31:0] req_log[$];

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        if (const_inst) return 32'h0000_0013;
        return {a[15:0], a[31:16]} ^ 32'hA5C3_0013;
    endfunction

    // One clock cycle: drive inputs, compare against the model, advance the model.
    task automatic step(input logic tv, input logic [31:0] tpc, input logic rv,
                        input logic [31:0] rpc, input logic ordy, input logic rrdy);
        logic        take, accept, resp_now, exp_req, next_mis;
        logic [31:0] tgt, tgt_eff;
        @(negedge clk);
        trap_valid     = tv;
        trap_pc        = tpc;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = ordy;
        req_ready      = rrdy;
        resp_now       = 1'b0;
        if (mem_busy && mem_cnt <= 1) resp_now = 1'b1;
        else if (mem_busy) mem_cnt--;
        if (exp_idle && late_resp) begin
            resp_valid = 1'b1;
            resp_inst  = 32'hDEAD_BEEF;
            late_resp  = 1'b0;
        end else if (resp_now) begin
            resp_valid = 1'b1;
            resp_inst  = inst_of(mem_addr);
        end else begin
            resp_valid = 1'b0;
            resp_inst  = $urandom;
        end
        #2;
        take = tv || rv;
        tgt  = tv ? tpc : rpc;
`ifdef YSYX_IFU_ALIGN_CHK_EN
        accept   = take && (tgt[1:0] == 2'b00);
        tgt_eff  = tgt;
        next_mis = take && (tgt[1:0] != 2'b00);
`else
        accept   = take;
        tgt_eff  = {tgt[31:2], 2'b00};
        next_mis = 1'b0;
`endif
        exp_req = !exp_idle && !exp_valid && !mem_busy && !take;

        n_tests++;
        if (req_valid !== exp_req) begin
            n_fail++;
            $display("FAIL req_valid @%0t: got %b, expected %b", $time, req_valid, exp_req);
        end
        if (exp_req) begin
            n_tests++;
            if (req_pc !== exp_pc) begin
                n_fail++;
                $display("FAIL req_pc @%0t: got %h, expected %h", $time, req_pc, exp_pc);
            end
        end
        n_tests++;
        if (out_valid !== exp_valid) begin
            n_fail++;
            $display("FAIL out_valid @%0t: got %b, expected %b", $time, out_valid, exp_valid);
        end
        if (exp_valid) begin
            n_tests++;
            if (out_pc !== exp_pc || out_inst !== exp_inst) begin
                n_fail++;
                $display("FAIL out_pc/out_inst @%0t: got %h/%h, expected %h/%h",
                         $time, out_pc, out_inst, exp_pc, exp_inst);
            end
        end
        n_tests++;
        if (snpc !== exp_pc + 32'd4) begin
            n_fail++;
            $display("FAIL snpc @%0t: got %h, expected %h", $time, snpc, exp_pc + 32'd4);
        end
        n_tests++;
        if (misalign_err !== exp_mis) begin
            n_fail++;
            $display("FAIL misalign_err @%0t: got %b, expected %b", $time, misalign_err, exp_mis);
        end

        last_hs         = req_valid && rrdy;
        last_hs_pc      = req_pc;
        last_deliver    = out_valid && ordy;
        last_deliver_pc = out_pc;
        if (last_hs) req_log.push_back(req_pc);

        if (exp_idle) begin
            exp_idle = 1'b0;
            if (accept) exp_pc = tgt_eff;
        end else if (exp_valid) begin
            if (accept) begin
                exp_valid = 1'b0;
                exp_pc    = tgt_eff;
            end else if (ordy) begin
                exp_valid = 1'b0;
                exp_pc    = exp_pc + 32'd4;
            end
        end else begin
            if (accept) exp_pc = tgt_eff;
            if (resp_now) begin
                if (!mem_killed && !accept) begin
                    exp_valid = 1'b1;
                    exp_inst  = inst_of(mem_addr);
                end
                mem_busy   = 1'b0;
                mem_killed = 1'b0;
            end else if (accept && mem_busy) begin
                mem_killed = 1'b1;
            end
            if (exp_req && rrdy) begin
                mem_busy   = 1'b1;
                mem_killed = 1'b0;
                mem_addr   = exp_pc;
                mem_cnt    = $urandom_range(lat_max, lat_min);
            end
        end
        exp_mis = next_mis;
    endtask

    task automatic idle_step(input logic ordy, input logic rrdy);
        step(1'b0, 32'h0, 1'b0, 32'h0, ordy, rrdy);
    endtask

    // Asynchronous reset mid-cycle; outputs must clear immediately.
    task automatic apply_reset();
        @(negedge clk);
        #1;
        rst            = 1'b0;
        trap_valid     = 1'b0;
        redirect_valid = 1'b0;
        resp_valid     = 1'b0;
        out_ready      = 1'b0;
        req_ready      = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_inst !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b pc=%h inst=%h, expected 0/0/0", out_valid, out_pc, out_inst);
        end
        n_tests++;
        if (req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_req_valid: got %b, expected 0", req_valid);
        end
        n_tests++;
        if (snpc !== RESET_VEC + 32'd4 || req_pc !== RESET_VEC) begin
            n_fail++;
            $display("FAIL reset_pc: got req_pc=%h snpc=%h, expected %h/%h", req_pc, snpc, RESET_VEC, RESET_VEC + 32'd4);
        end
        n_tests++;
        if (misalign_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_misalign: got %b, expected 0", misalign_err);
        end
        exp_pc     = RESET_VEC;
        exp_idle   = 1'b1;
        exp_valid  = 1'b0;
        exp_inst   = '0;
        exp_mis    = 1'b0;
        mem_busy   = 1'b0;
        mem_killed = 1'b0;
        mem_cnt    = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic wait_hs(input logic ordy, input string name);
        int n = 0;
        idle_step(ordy, 1'b1);
        while (!last_hs && n < 50) begin
            idle_step(ordy, 1'b1);
            n++;
        end
        if (!last_hs) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got no request, expected one within 50 cycles", name);
        end
    endtask

    task automatic test_reset();
        const_inst = 1'b1;
        lat_min    = 1;
        lat_max    = 1;
        apply_reset();
        req_log.delete();
        repeat (14) idle_step(1'b1, 1'b1);
        n_tests++;
        if (req_log.size() < 3) begin
            n_fail++;
            $display("FAIL reset_seq_len: got %0d requests, expected >= 3", req_log.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if (req_log[i] !== RESET_VEC + 32'(4 * i)) begin
                    n_fail++;
                    $display("FAIL reset_seq[%0d]: got %h, expected %h", i, req_log[i], RESET_VEC + 32'(4 * i));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] p, ins;
        int n = 0;
        const_inst = 1'b0;
        idle_step(1'b0, 1'b1);
        while (out_valid !== 1'b1 && n < 50) begin
            idle_step(1'b0, 1'b1);
            n++;
        end
        p   = out_pc;
        ins = out_inst;
        for (int i = 0; i < 5; i++) begin
            idle_step(1'b0, 1'b1);
            n_tests++;
            if (out_valid !== 1'b1 || out_pc !== p || out_inst !== ins || req_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL backpressure_hold[%0d]: got v=%b pc=%h inst=%h req=%b, expected 1/%h/%h/0",
                         i, out_valid, out_pc, out_inst, req_valid, p, ins);
            end
        end
        idle_step(1'b1, 1'b1);
        wait_hs(1'b1, "backpressure");
        n_tests++;
        if (last_hs_pc !== p + 32'd4) begin
            n_fail++;
            $display("FAIL backpressure_next_pc: got %h, expected %h", last_hs_pc, p + 32'd4);
        end
    endtask

    task automatic test_kill();
        int n = 0;
        lat_min = 3;
        lat_max = 3;
        wait_hs(1'b1, "kill_setup");
        step(1'b0, 32'h0, 1'b1, 32'h8000_0100, 1'b1, 1'b1);
        idle_step(1'b1, 1'b1);
        while (!last_hs && n < 20) begin
            n_tests++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL kill_leak: got out_valid=%b out_pc=%h, expected out_valid=0", out_valid, out_pc);
            end
            idle_step(1'b1, 1'b1);
            n++;
        end
        n_tests++;
        if (!last_hs || last_hs_pc !== 32'h8000_0100) begin
            n_fail++;
            $display("FAIL kill_next_pc: got hs=%b pc=%h, expected 1/80000100", last_hs, last_hs_pc);
        end
        lat_min = 1;
        lat_max = 1;
    endtask

    task automatic test_priority();
        int n = 0;
        idle_step(1'b1, 1'b0);
        while (req_valid !== 1'b1 && n < 50) begin
            idle_step(1'b1, 1'b0);
            n++;
        end
        step(1'b1, 32'h8000_0200, 1'b1, 32'h8000_0100, 1'b1, 1'b1);
        wait_hs(1'b1, "priority");
        n_tests++;
        if (last_hs_pc !== 32'h8000_0200) begin
            n_fail++;
            $display("FAIL priority_next_pc: got %h, expected 80000200", last_hs_pc);
        end
    endtask

    task automatic test_wrap();
        int n = 0;
        step(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
        idle_step(1'b1, 1'b1);
        while (!last_deliver && n < 50) begin
            idle_step(1'b1, 1'b1);
            n++;
        end
        n_tests++;
        if (!last_deliver || last_deliver_pc !== 32'hFFFF_FFFC) begin
            n_fail++;
            $display("FAIL wrap_deliver: got v=%b pc=%h, expected 1/fffffffc", last_deliver, last_deliver_pc);
        end
        wait_hs(1'b1, "wrap");
        n_tests++;
        if (last_hs_pc !== 32'h0000_0000) begin
            n_fail++;
            $display("FAIL wrap_next_pc: got %h, expected 00000000", last_hs_pc);
        end
    endtask

    task automatic test_misalign();
        logic [31:0] p;
        int n = 0;
        idle_step(1'b1, 1'b0);
        while (req_valid !== 1'b1 && n < 50) begin
            idle_step(1'b1, 1'b0);
            n++;
        end
        p = req_pc;
        step(1'b0, 32'h0, 1'b1, 32'h8000_0102, 1'b1, 1'b0);
        idle_step(1'b1, 1'b0);
`ifdef YSYX_IFU_ALIGN_CHK_EN
        n_tests++;
        if (misalign_err !== 1'b1) begin
            n_fail++;
            $display("FAIL misalign_pulse: got %b, expected 1", misalign_err);
        end
        idle_step(1'b1, 1'b0);
        n_tests++;
        if (misalign_err !== 1'b0) begin
            n_fail++;
            $display("FAIL misalign_pulse_len: got %b, expected 0", misalign_err);
        end
        wait_hs(1'b1, "misalign");
        n_tests++;
        if (last_hs_pc !== p) begin
            n_fail++;
            $display("FAIL misalign_pc_kept: got %h, expected %h", last_hs_pc, p);
        end
`else
        n_tests++;
        if (misalign_err !== 1'b0 || req_pc === p) begin
            n_fail++;
            $display("FAIL misalign_tied: got err=%b req_pc=%h, expected err=0 and pc moved from %h", misalign_err, req_pc, p);
        end
        wait_hs(1'b1, "misalign");
        n_tests++;
        if (last_hs_pc !== 32'h8000_0100) begin
            n_fail++;
            $display("FAIL misalign_aligned_pc: got %h, expected 80000100", last_hs_pc);
        end
`endif
    endtask

    task automatic test_random();
        logic        tv, rv;
        logic [31:0] tpc, rpc;
        const_inst = 1'b0;
        lat_min    = 1;
        lat_max    = 3;
        for (int i = 0; i < 1500; i++) begin
            tv  = ($urandom % 40) == 0;
            rv  = ($urandom % 12) == 0;
            tpc = $urandom;
            rpc = ($urandom % 8 == 0) ? 32'hFFFF_FFFC : $urandom;
`ifdef YSYX_IFU_ALIGN_CHK_EN
            tpc[1:0] = 2'b00;
            rpc[1:0] = 2'b00;
`endif
            step(tv, tpc, rv, rpc, ($urandom % 4) != 0, ($urandom % 3) != 0);
        end
        lat_min = 1;
        lat_max = 1;
    endtask

    task automatic test_reset_mid();
        int n = 0;
        idle_step(1'b0, 1'b1);
        while (out_valid !== 1'b1 && n < 50) begin
            idle_step(1'b0, 1'b1);
            n++;
        end
        apply_reset();
        late_resp = 1'b1;
        idle_step(1'b1, 1'b1);
        idle_step(1'b1, 1'b1);
        n_tests++;
        if (!last_hs || last_hs_pc !== RESET_VEC) begin
            n_fail++;
            $display("FAIL reset_mid_fetch: got hs=%b pc=%h, expected 1/%h", last_hs, last_hs_pc, RESET_VEC);
        end
        repeat (6) idle_step(1'b1, 1'b1);
    endtask

    initial begin
        test_reset();
        test_backpressure();
        test_kill();
        test_priority();
        test_wrap();
        test_misalign();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
